cpu_branch_tracker: RTL and testbench

//  Producer side of the branch predictor's update interface. Records each fetched branch's

---
 rtl/cpu_branch_tracker.sv | 137 +++++++++++++
 tb/tb_cpu_branch_tracker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cpu_branch_tracker.sv
// rtl/cpu_branch_tracker.sv - in-order branch prediction tracker feeding predictor updates
//
// Purpose: queues each fetched branch's prediction (pc, direction, target). When
// execute resolves the oldest branch, the head entry is popped, a predictor update
// is strobed, and a mispredict with the correct redirect PC is raised if needed.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   push_valid/ready, push_*       fetch side: predicted branch entering the queue
//   resolve_valid, resolve_*       execute side: actual outcome of the oldest branch
//   flush                          external pipeline flush, clears the queue
//   update, update_addr/taken      registered predictor update strobe and payload
//   mispredict, redirect_pc        registered fetch redirect pulse and target
//   err                            registered protocol-violation pulse
//   count                          entries currently queued
module cpu_branch_tracker #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WIDTH = 2,
    parameter int INSN_BYTES  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [XLEN-1:0]        push_pc,
    input  logic                   push_pred_taken,
    input  logic [XLEN-1:0]        push_pred_target,
    input  logic                   resolve_valid,
    input  logic [XLEN-1:0]        resolve_pc,
    input  logic                   resolve_taken,
    input  logic [XLEN-1:0]        resolve_target,
    input  logic                   flush,
    output logic                   update,
    output logic [XLEN-1:0]        update_addr,
    output logic                   update_taken,
    output logic                   mispredict,
    output logic [XLEN-1:0]        redirect_pc,
    output logic                   err,
    output logic [DEPTH_WIDTH:0]   count
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL = {1'b1, {DEPTH_WIDTH{1'b0}}};

    logic [XLEN-1:0]        pc_mem  [DEPTH];
    logic [XLEN-1:0]        tgt_mem [DEPTH];
    logic [DEPTH-1:0]       taken_mem;

    logic [DEPTH_WIDTH-1:0] head_q, tail_q;
    logic [DEPTH_WIDTH:0]   count_q;
    logic                   update_q, update_taken_q, mispredict_q, err_q;
    logic [XLEN-1:0]        update_addr_q, redirect_pc_q;

    logic                   push_fire, res_fire, res_empty;
    logic                   head_match, dir_wrong, tgt_wrong, mispred_d;
    logic [XLEN-1:0]        head_pc, redirect_d;

    assign push_ready = (count_q != FULL);
    assign count      = count_q;

    assign push_fire  = push_valid && push_ready;
    assign res_fire   = resolve_valid && (count_q != '0);
    assign res_empty  = resolve_valid && (count_q == '0);

    assign head_pc    = pc_mem[head_q];
    assign head_match = (head_pc == resolve_pc);
    assign dir_wrong  = (taken_mem[head_q] != resolve_taken);
    // Target only matters when both prediction and outcome say taken.
    assign tgt_wrong  = taken_mem[head_q] && resolve_taken && (tgt_mem[head_q] != resolve_target);
    // A PC mismatch means the queue is out of sync with execute: treat as mispredict too.
    assign mispred_d  = res_fire && (!head_match || dir_wrong || tgt_wrong);
    assign redirect_d = resolve_taken ? resolve_target : (resolve_pc + XLEN'(INSN_BYTES));

    // Payload storage needs no reset: entries are only read when count marks them valid.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[tail_q]    <= push_pc;
            tgt_mem[tail_q]   <= push_pred_target;
            taken_mem[tail_q] <= push_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            update_q       <= 1'b0;
            update_addr_q  <= '0;
            update_taken_q <= 1'b0;
            mispredict_q   <= 1'b0;
            redirect_pc_q  <= '0;
            err_q          <= 1'b0;
        end else if (flush) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            update_q     <= 1'b0;
            mispredict_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            update_q     <= res_fire && head_match;
            mispredict_q <= mispred_d;
            err_q        <= res_empty || (res_fire && !head_match);
            if (res_fire && head_match) begin
                update_addr_q  <= head_pc;
                update_taken_q <= resolve_taken;
            end
            if (mispred_d) begin
                redirect_pc_q <= redirect_d;
            end
            // Everything younger than a mispredicted branch is wrong-path: drop it all,
            // including a push arriving in the same cycle.
            if (mispred_d) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_fire) tail_q <= tail_q + 1'b1;
                if (res_fire)  head_q <= head_q + 1'b1;
                case ({push_fire, res_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign update       = update_q;
    assign update_addr  = update_addr_q;
    assign update_taken = update_taken_q;
    assign mispredict   = mispredict_q;
    assign redirect_pc  = redirect_pc_q;
    assign err          = err_q;

endmodule

// File: tb/tb_cpu_branch_tracker.sv
// tb/tb_cpu_branch_tracker.sv - directed table-driven bench for cpu_branch_tracker
module tb_cpu_branch_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0, push_pred_taken = 1'b0;
    logic        push_ready;
    logic [31:0] push_pc = '0, push_pred_target = '0;
    logic        resolve_valid = 1'b0, resolve_taken = 1'b0, flush = 1'b0;
    logic [31:0] resolve_pc = '0, resolve_target = '0;
    logic        update, update_taken, mispredict, err;
    logic [31:0] update_addr, redirect_pc;
    logic [2:0]  count;

    always #5 clk = ~clk;

    cpu_branch_tracker #(.XLEN(32), .DEPTH_WIDTH(2), .INSN_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .flush(flush), .update(update), .update_addr(update_addr),
        .update_taken(update_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .err(err), .count(count)
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic [31:0] ppc;
        logic        pt;
        logic [31:0] ptg;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic [31:0] rtg;
        logic        fl;
        logic        eu;
        logic [31:0] ea;
        logic        et;
        logic        em;
        logic [31:0] er;
        logic        ee;
        logic [2:0]  ec;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic rst, input logic pv, input logic [31:0] ppc,
                       input logic pt, input logic [31:0] ptg, input logic rv,
                       input logic [31:0] rpc, input logic rt, input logic [31:0] rtg,
                       input logic fl, input logic eu, input logic [31:0] ea,
                       input logic et, input logic em, input logic [31:0] er,
                       input logic ee, input logic [2:0] ec, input logic erdy);
        vec_t v;
        v.rst = rst; v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptg = ptg;
        v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtg = rtg; v.fl = fl;
        v.eu = eu; v.ea = ea; v.et = et; v.em = em; v.er = er;
        v.ee = ee; v.ec = ec; v.erdy = erdy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst; push_valid = v.pv; push_pc = v.ppc; push_pred_taken = v.pt;
        push_pred_target = v.ptg; resolve_valid = v.rv; resolve_pc = v.rpc;
        resolve_taken = v.rt; resolve_target = v.rtg; flush = v.fl;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; push_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        // reset and basic correct prediction
        add(0, 0,0,0,0,            0,0,0,0,            0, 0,0,0, 0,0, 0,0,1);
        add(1, 1,'h100,1,'h200,    0,0,0,0,            0, 0,0,0, 0,0, 0,1,1);
        add(1, 0,0,0,0,            1,'h100,1,'h200,    0, 1,'h100,1, 0,0, 0,0,1);
        add(1, 0,0,0,0,            0,0,0,0,            0, 0,0,0, 0,0, 0,0,1);
        // direction mispredict discards the younger 0x104
        add(1, 1,'h100,0,0,        0,0,0,0,            0, 0,0,0, 0,0, 0,1,1);
        add(1, 1,'h104,0,0,        0,0,0,0,            0, 0,0,0, 0,0, 0,2,1);
        add(1, 0,0,0,0,            1,'h100,1,'h40,     0, 1,'h100,1, 1,'h40, 0,0,1);
        add(1, 0,0,0,0,            0,0,0,0,            0, 0,0,0, 0,0, 0,0,1);
        // target mispredict
        add(1, 1,'h10,1,'h80,      0,0,0,0,            0, 0,0,0, 0,0, 0,1,1);
        add(1, 0,0,0,0,            1,'h10,1,'h90,      0, 1,'h10,1, 1,'h90, 0,0,1);
        // predicted taken, actually not taken -> fall-through redirect
        add(1, 1,'h20,1,'h80,      0,0,0,0,            0, 0,0,0, 0,0, 0,1,1);
        add(1, 0,0,0,0,            1,'h20,0,'h55,      0, 1,'h20,0, 1,'h24, 0,0,1);
        // fill to full
        for (int i = 0; i < 4; i++)
            add(1, 1,32'h1000 + 32'(4*i),0,0, 0,0,0,0, 0, 0,0,0, 0,0, 0,3'(i+1),(i != 3));
        // full: push dropped, resolve pops
        add(1, 1,'h2000,0,0,       1,'h1000,0,0,       0, 1,'h1000,0, 0,0, 0,3,1);
        // 10 push/resolve pairs across pointer wrap
        for (int i = 0; i < 10; i++) begin
            logic [31:0] hp;
            hp = (i < 3) ? 32'h1004 + 32'(4*i) : 32'h3000 + 32'(4*(i-3));
            add(1, 1,32'h3000 + 32'(4*i),0,0, 1,hp,0,0, 0, 1,hp,0, 0,0, 0,3,1);
        end
        // flush beats push and resolve
        add(1, 1,'h5000,0,0,       1,'h301C,0,0,       1, 0,0,0, 0,0, 0,0,1);
        // resolve while empty: err, same-cycle push accepted
        add(1, 1,'h100,1,'h200,    1,'h40,0,0,         0, 0,0,0, 0,0, 1,1,1);
        add(1, 0,0,0,0,            0,0,0,0,            0, 0,0,0, 0,0, 0,1,1);
        // pc mismatch: err + mispredict, queue cleared
        add(1, 0,0,0,0,            1,'h104,1,'h300,    0, 0,0,0, 1,'h300, 1,0,1);
        add(1, 0,0,0,0,            0,0,0,0,            0, 0,0,0, 0,0, 0,0,1);
        // fall-through wraps modulo 2**XLEN
        add(1, 1,'hFFFFFFFC,1,'h10, 0,0,0,0,           0, 0,0,0, 0,0, 0,1,1);
        add(1, 0,0,0,0,            1,'hFFFFFFFC,0,0,   0, 1,'hFFFFFFFC,0, 1,'h0, 0,0,1);
        // reset mid-queue
        add(1, 1,'hA0,0,0,         0,0,0,0,            0, 0,0,0, 0,0, 0,1,1);
        add(1, 1,'hA4,0,0,         0,0,0,0,            0, 0,0,0, 0,0, 0,2,1);
        add(1, 1,'hA8,0,0,         0,0,0,0,            0, 0,0,0, 0,0, 0,3,1);
        add(1, 0,0,0,0,            1,'hA0,0,0,         0, 1,'hA0,0, 0,0, 0,2,1);
        add(0, 1,'hAC,0,0,         1,'hA4,1,'h99,      0, 0,0,0, 0,0, 0,0,1);
        add(1, 1,'hB0,0,0,         0,0,0,0,            0, 0,0,0, 0,0, 0,1,1);
        add(1, 0,0,0,0,            1,'hB0,0,0,         0, 1,'hB0,0, 0,0, 0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d update", i),     {31'b0, update},     {31'b0, vecs[i].eu});
            chk($sformatf("v%0d mispredict", i), {31'b0, mispredict}, {31'b0, vecs[i].em});
            chk($sformatf("v%0d err", i),        {31'b0, err},        {31'b0, vecs[i].ee});
            chk($sformatf("v%0d count", i),      {29'b0, count},      {29'b0, vecs[i].ec});
            chk($sformatf("v%0d push_ready", i), {31'b0, push_ready}, {31'b0, vecs[i].erdy});
            if (vecs[i].eu)
                chk($sformatf("v%0d update_taken", i), {31'b0, update_taken}, {31'b0, vecs[i].et});
            if (vecs[i].eu || !vecs[i].rst)
                chk($sformatf("v%0d update_addr", i), update_addr, vecs[i].ea);
            if (vecs[i].em || !vecs[i].rst)
                chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].er);
        end

        // Hand sequence: a push in the same cycle as a mispredicting resolve is dropped,
        // and the mispredict pulse lasts one cycle.
        @(negedge clk);
        idle_inputs();
        push_valid = 1'b1; push_pc = 32'hC0; push_pred_taken = 1'b1; push_pred_target = 32'hD0;
        @(posedge clk); #1;
        chk("seq count after push", {29'b0, count}, 32'd1);
        @(negedge clk);
        push_pc = 32'hC4; push_pred_taken = 1'b0;
        resolve_valid = 1'b1; resolve_pc = 32'hC0; resolve_taken = 1'b1; resolve_target = 32'hE0;
        @(posedge clk); #1;
        chk("seq mispredict", {31'b0, mispredict}, 32'd1);
        chk("seq redirect", redirect_pc, 32'hE0);
        chk("seq count cleared", {29'b0, count}, 32'd0);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        chk("seq mispredict pulse", {31'b0, mispredict}, 32'd0);
        chk("seq push dropped", {29'b0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
